// File: rtl/fp_core_arbiter.sv
// Round-robin arbiter that shares one fp_core (Montgomery multiply / modular add-sub)
// between NREQ requester engines, with a watchdog that bounds every multiply.
module fp_core_arbiter #(
   parameter int NREQ    = 2,
   parameter int W       = 256,
   parameter int TIMEOUT = 1023
) (
   input  logic                 clk,
   input  logic                 rst_b,
   input  logic [NREQ-1:0]      req,
   input  logic [3*NREQ-1:0]    req_op,
   input  logic [W*NREQ-1:0]    req_ina,
   input  logic [W*NREQ-1:0]    req_inb,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [W-1:0]         rsp_data,
   output logic                 rsp_err,
   output logic                 busy,
   output logic [2:0]           fp_select,
   output logic [W-1:0]         fp_ina,
   output logic [W-1:0]         fp_inb,
   input  logic [W-1:0]         fp_mm,
   input  logic                 fp_end_mm,
   input  logic [W-1:0]         fp_as,
   output logic [1:0]           dbg_state
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [2:0] OP_MM = 3'b100;
   localparam logic [2:0] OP_AS = 3'b010;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_EXEC_MM = 2'd1,
      S_EXEC_AS = 2'd2,
      S_RESP    = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   rr_ptr_q;
   logic [IW-1:0]   win_q;
   logic [2:0]      op_q;
   logic [W-1:0]    ina_q;
   logic [W-1:0]    inb_q;
   logic [CW-1:0]   mm_cnt_q;
   logic [W-1:0]    rsp_data_q;
   logic            rsp_err_q;

   logic            found;
   logic [IW-1:0]   win_idx;
   logic [IW-1:0]   cand;
   logic [IW:0]     sum;
   logic [2:0]      win_op;
   logic            mm_timeout;

   // Search rr_ptr, rr_ptr+1, ... (mod NREQ) for the first active request.
   always_comb begin
      found   = 1'b0;
      win_idx = '0;
      cand    = '0;
      sum     = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
         if (sum >= (IW+1)'(NREQ)) sum = sum - (IW+1)'(NREQ);
         cand = sum[IW-1:0];
         if (!found && req[cand]) begin
            found   = 1'b1;
            win_idx = cand;
         end
      end
   end

   assign win_op     = req_op[3*win_idx +: 3];
   assign mm_timeout = (mm_cnt_q == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               if (win_op == OP_MM)      state_d = S_EXEC_MM;
               else if (win_op == OP_AS) state_d = S_EXEC_AS;
               else                      state_d = S_RESP;
            end
         end
         S_EXEC_MM: if (fp_end_mm || mm_timeout) state_d = S_RESP;
         S_EXEC_AS: state_d = S_RESP;
         S_RESP:    state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // gnt is gated by rst_b so every output reads 0 while reset is asserted.
   always_comb begin
      gnt       = '0;
      rsp_valid = '0;
      fp_select = 3'b000;
      fp_ina    = '0;
      fp_inb    = '0;
      busy      = 1'b1;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (found && rst_b) gnt[win_idx] = 1'b1;
         end
         S_EXEC_MM, S_EXEC_AS: begin
            fp_select = op_q;
            fp_ina    = ina_q;
            fp_inb    = inb_q;
         end
         S_RESP:  rsp_valid[win_q] = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         rr_ptr_q   <= '0;
         win_q      <= '0;
         op_q       <= '0;
         ina_q      <= '0;
         inb_q      <= '0;
         mm_cnt_q   <= '0;
         rsp_data_q <= '0;
         rsp_err_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (found) begin
                  op_q     <= win_op;
                  ina_q    <= req_ina[W*win_idx +: W];
                  inb_q    <= req_inb[W*win_idx +: W];
                  win_q    <= win_idx;
                  rr_ptr_q <= (win_idx == IW'(NREQ - 1)) ? '0 : win_idx + IW'(1);
                  mm_cnt_q <= '0;
                  // Unknown op codes never touch the core and answer with an error.
                  if (win_op != OP_MM && win_op != OP_AS) begin
                     rsp_err_q  <= 1'b1;
                     rsp_data_q <= '0;
                  end
               end
            end
            S_EXEC_MM: begin
               mm_cnt_q <= mm_cnt_q + CW'(1);
               if (fp_end_mm) begin
                  rsp_data_q <= fp_mm;
                  rsp_err_q  <= 1'b0;
               end else if (mm_timeout) begin
                  rsp_data_q <= '0;
                  rsp_err_q  <= 1'b1;
               end
            end
            S_EXEC_AS: begin
               rsp_data_q <= fp_as;
               rsp_err_q  <= 1'b0;
            end
            S_RESP: begin
               rsp_data_q <= '0;
               rsp_err_q  <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_fp_core_arbiter.sv
// Bench for fp_core_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model of round-robin arbitration and core results.
module tb_fp_core_arbiter;

   localparam int NREQ    = 2;
   localparam int W       = 32;
   localparam int TIMEOUT = 24;
   localparam logic [2:0] OP_MM = 3'b100;
   localparam logic [2:0] OP_AS = 3'b010;

   logic                clk = 1'b0;
   logic                rst_b;
   logic [NREQ-1:0]     req;
   logic [3*NREQ-1:0]   req_op;
   logic [W*NREQ-1:0]   req_ina;
   logic [W*NREQ-1:0]   req_inb;
   logic [NREQ-1:0]     gnt;
   logic [NREQ-1:0]     rsp_valid;
   logic [W-1:0]        rsp_data;
   logic                rsp_err;
   logic                busy;
   logic [2:0]          fp_select;
   logic [W-1:0]        fp_ina;
   logic [W-1:0]        fp_inb;
   logic [W-1:0]        fp_mm;
   logic                fp_end_mm;
   logic [W-1:0]        fp_as;
   logic [1:0]          dbg_state;

   int tests  = 0;
   int failed = 0;
   int rr_model = 0;
   logic [W-1:0] exp_q[$];

   fp_core_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .rst_b     (rst_b),
      .req       (req),
      .req_op    (req_op),
      .req_ina   (req_ina),
      .req_inb   (req_inb),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .fp_select (fp_select),
      .fp_ina    (fp_ina),
      .fp_inb    (fp_inb),
      .fp_mm     (fp_mm),
      .fp_end_mm (fp_end_mm),
      .fp_as     (fp_as),
      .dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // Core add/sub path modelled as a - b, only meaningful while the core is selected for it.
   assign fp_as = (fp_select == OP_AS) ? fp_ina - fp_inb : '0;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int model_winner(input logic [NREQ-1:0] r, input int ptr);
      for (int k = 0; k < NREQ; k++)
         if (r[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      return -1;
   endfunction

   function automatic logic [2:0] pick_op();
      logic [2:0] bad [6] = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b110, 3'b111};
      int sel = $urandom_range(0, 5);
      if (sel < 3) return OP_AS;
      if (sel < 5) return OP_MM;
      return bad[$urandom_range(0, 5)];
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_gnt"},   gnt, 0);
      check({tag, "_valid"}, rsp_valid, 0);
      check({tag, "_data"},  rsp_data, 0);
      check({tag, "_err"},   rsp_err, 0);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_sel"},   fp_select, 0);
      check({tag, "_ina"},   fp_ina, 0);
      check({tag, "_inb"},   fp_inb, 0);
   endtask

   // One complete transaction from an IDLE cycle with req already driven.
   task automatic run_one(input int mm_lat, input logic [W-1:0] mm_val, input bit scramble);
      int w, n;
      logic [2:0]   op;
      logic [W-1:0] a, b, exp_d;
      logic         exp_e;
      #1;
      w = model_winner(req, rr_model);
      if (w < 0) w = 0;
      op = req_op[3*w +: 3];
      a  = req_ina[W*w +: W];
      b  = req_inb[W*w +: W];
      check("gnt", gnt, 64'(1) << w);
      check("sel_idle", fp_select, 0);
      rr_model = (w + 1) % NREQ;
      tick();
      if (scramble) begin
         req     = NREQ'($urandom_range(0, 3));
         req_op  = 6'($urandom);
         req_ina = {$urandom, $urandom};
         req_inb = {$urandom, $urandom};
      end
      exp_e = 1'b0;
      if (op == OP_AS) begin
         exp_q.push_back(a - b);
         check("as_sel", fp_select, OP_AS);
         check("as_ina", fp_ina, a);
         check("as_inb", fp_inb, b);
         check("as_gnt", gnt, 0);
         check("as_busy", busy, 1);
         tick();
      end else if (op == OP_MM) begin
         n     = (mm_lat <= TIMEOUT) ? mm_lat : TIMEOUT;
         exp_e = (mm_lat > TIMEOUT);
         exp_q.push_back(exp_e ? '0 : mm_val);
         for (int i = 1; i <= n; i++) begin
            check("mm_sel", fp_select, OP_MM);
            check("mm_ina", fp_ina, a);
            check("mm_inb", fp_inb, b);
            check("mm_novalid", rsp_valid, 0);
            if (i == mm_lat) begin
               fp_end_mm = 1'b1;
               fp_mm     = mm_val;
            end
            tick();
            fp_end_mm = 1'b0;
            fp_mm     = W'($urandom);
         end
      end else begin
         exp_q.push_back('0);
         exp_e = 1'b1;
      end
      exp_d = exp_q.pop_front();
      check("rsp_valid", rsp_valid, 64'(1) << w);
      check("rsp_data", rsp_data, exp_d);
      check("rsp_err", rsp_err, exp_e);
      check("rsp_sel", fp_select, 0);
      check("rsp_busy", busy, 1);
      tick();
      check("idle_valid", rsp_valid, 0);
      check("idle_data", rsp_data, 0);
      check("idle_err", rsp_err, 0);
      check("idle_busy", busy, 0);
   endtask

   initial begin
      // Reset
      rst_b = 1'b0; req = '0; req_op = '0; req_ina = '0; req_inb = '0;
      fp_mm = '0; fp_end_mm = 1'b0;
      tick(); tick();
      check_all_zero("reset");
      check("reset_state", dbg_state, 0);
      rst_b = 1'b1;
      tick();

      // T1: add/sub 5 - 3 from requester 0
      req = 2'b01; req_op[2:0] = OP_AS; req_ina[W-1:0] = 5; req_inb[W-1:0] = 3;
      run_one(0, '0, 1'b0);

      // T2: multiply from requester 1, end_mm after 20 cycles
      req = 2'b10; req_op[5:3] = OP_MM; req_ina[W +: W] = W'($urandom); req_inb[W +: W] = W'($urandom);
      run_one(20, W'('h1234), 1'b0);

      // T4: invalid op
      req = 2'b01; req_op[2:0] = 3'b111;
      run_one(0, '0, 1'b0);

      // T5: watchdog expiry, then end_mm exactly on the last allowed cycle, then one earlier
      req = 2'b01; req_op[2:0] = OP_MM; req_ina[W-1:0] = W'($urandom); req_inb[W-1:0] = W'($urandom);
      run_one(TIMEOUT + 5, W'($urandom), 1'b0);
      run_one(TIMEOUT, W'($urandom), 1'b0);
      run_one(TIMEOUT - 1, W'($urandom), 1'b0);
      run_one(1, W'($urandom), 1'b0);

      // T3: both requesters held from reset, four add/sub ops alternate 0,1,0,1
      rst_b = 1'b0; req = '0;
      tick();
      rst_b = 1'b1; rr_model = 0;
      req = 2'b11; req_op = {OP_AS, OP_AS};
      for (int k = 0; k < 4; k++) begin
         req_ina = {$urandom, $urandom};
         req_inb = {$urandom, $urandom};
         run_one(0, '0, 1'b0);
      end

      // Randomized traffic
      for (int it = 0; it < 40; it++) begin
         req = NREQ'($urandom_range(1, 3));
         for (int r = 0; r < NREQ; r++) begin
            req_op[3*r +: 3]  = pick_op();
            req_ina[W*r +: W] = W'($urandom);
            req_inb[W*r +: W] = W'($urandom);
         end
         run_one($urandom_range(1, TIMEOUT + 3), W'($urandom), 1'b1);
      end

      // T6: reset in the middle of a multiply
      req = 2'b01; req_op[2:0] = OP_MM; req_ina[W-1:0] = W'($urandom); req_inb[W-1:0] = W'($urandom);
      #1;
      check("t6_gnt", gnt, 64'(model_winner(req, rr_model) == 0));
      tick(); tick(); tick();
      check("t6_mm_sel", fp_select, OP_MM);
      rst_b = 1'b0;
      #1;
      check_all_zero("t6_rst");
      req = '0;
      tick(); tick();
      rst_b = 1'b1;
      rr_model = 0;
      exp_q.delete();
      for (int k = 0; k < 4; k++) begin
         tick();
         check("t6_no_valid", rsp_valid, 0);
         check("t6_idle", busy, 0);
      end
      req = 2'b11; req_op = {OP_AS, OP_AS};
      req_ina = {$urandom, $urandom}; req_inb = {$urandom, $urandom};
      run_one(0, '0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
